bcrypt_seq: RTL and testbench



---
 rtl/bcrypt_seq_pkg.sv | 35 +++
 rtl/bcrypt_seq_if.sv | 44 ++++
 rtl/bcrypt_wr_addr_gen.sv | 86 ++++++++
 rtl/bcrypt_seq.sv | 204 ++++++++++++++++++++
 tb/tb_bcrypt_seq.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/bcrypt_seq_pkg.sv
// bcrypt_pkg: shared types and width helpers for the bcrypt sequencer.
//   phase_t : top-level schedule phase (IDLE, SETUP, LOOP_KEY, LOOP_SALT, CTEXT)
//   sub_t   : per-block sub-state within a phase (XOR, ISSUE, WAIT, WRITE)
//   idx_w   : index width for n items, never narrower than 1 bit
//   addr_w  : S-box pair address width for a given S-box word count
package bcrypt_pkg;

  localparam int unsigned PHASE_W = 3;
  localparam int unsigned P_IDX_W = 4;
  localparam int unsigned PERF_W  = 32;

  typedef enum logic [PHASE_W-1:0] {
    PH_IDLE      = 3'd0,
    PH_SETUP     = 3'd1,
    PH_LOOP_KEY  = 3'd2,
    PH_LOOP_SALT = 3'd3,
    PH_CTEXT     = 3'd4
  } phase_t;

  typedef enum logic [1:0] {
    SUB_XOR,
    SUB_ISSUE,
    SUB_WAIT,
    SUB_WRITE
  } sub_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned addr_w(input int unsigned sbox_words);
    return idx_w(sbox_words / 2);
  endfunction

endpackage

// File: rtl/bcrypt_seq_if.sv
// bcrypt_seq_if: host and Feistel-core signals of the bcrypt sequencer.
//   master : the sequencer (drives status, strobes and write addressing)
//   slave  : host / Feistel core side (drives start, cost, blk_done)
interface bcrypt_seq_if
  import bcrypt_pkg::*;
#(
  parameter int unsigned COST_W       = 5,
  parameter int unsigned NUM_SBOX     = 4,
  parameter int unsigned SBOX_WORDS   = 256,
  parameter int unsigned CTEXT_BLOCKS = 3
);

  logic                                 start;
  logic [COST_W-1:0]                    cost;
  logic                                 busy;
  logic                                 done;
  logic [PHASE_W-1:0]                   phase;
  logic                                 xor_p;
  logic                                 salt_key_sel;
  logic                                 mix_salt;
  logic                                 salt_half;
  logic                                 blk_start;
  logic                                 blk_done;
  logic                                 wr_en;
  logic                                 wr_p;
  logic [P_IDX_W-1:0]                   p_idx;
  logic [NUM_SBOX-1:0]                  wr_cs;
  logic [addr_w(SBOX_WORDS)-1:0]        wr_addr;
  logic                                 ct_wr;
  logic [idx_w(CTEXT_BLOCKS)-1:0]       ct_idx;

  modport master (
    input  start, cost, blk_done,
    output busy, done, phase, xor_p, salt_key_sel, mix_salt, salt_half,
           blk_start, wr_en, wr_p, p_idx, wr_cs, wr_addr, ct_wr, ct_idx
  );

  modport slave (
    output start, cost, blk_done,
    input  busy, done, phase, xor_p, salt_key_sel, mix_salt, salt_half,
           blk_start, wr_en, wr_p, p_idx, wr_cs, wr_addr, ct_wr, ct_idx
  );

endinterface

// File: rtl/bcrypt_wr_addr_gen.sv
// bcrypt_wr_addr_gen: write-target walker for one key expansion.
// Walks P pairs 0..P_PAIRS-1, then each S-box bank's pair addresses in order.
//   clr_i        : restart at P pair 0 (asserted in the XOR sub-state)
//   adv_i        : step to the next write target (asserted in WRITE)
//   wr_p_o       : current target is the P-array
//   p_idx_o      : P-pair index
//   wr_cs_o      : one-hot S-box bank select, zero while on the P-array
//   wr_addr_o    : S-box pair address
//   last_write_c : current target is the final one of the expansion
module bcrypt_wr_addr_gen
  import bcrypt_pkg::*;
#(
  parameter int unsigned P_PAIRS    = 9,
  parameter int unsigned NUM_SBOX   = 4,
  parameter int unsigned SBOX_WORDS = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr_i,
  input  logic                          adv_i,
  output logic                          wr_p_o,
  output logic [P_IDX_W-1:0]            p_idx_o,
  output logic [NUM_SBOX-1:0]           wr_cs_o,
  output logic [addr_w(SBOX_WORDS)-1:0] wr_addr_o,
  output logic                          last_write_c
);

  localparam int unsigned ADDR_W    = addr_w(SBOX_WORDS);
  localparam int unsigned ADDR_LAST = SBOX_WORDS / 2 - 1;
  localparam int unsigned P_LAST    = P_PAIRS - 1;

  logic                wr_p_q, wr_p_d;
  logic [P_IDX_W-1:0]  p_q, p_d;
  logic [NUM_SBOX-1:0] cs_q, cs_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;

  // Next target: P pairs first, then bank-by-bank with the address wrapping.
  always_comb begin
    wr_p_d = wr_p_q;
    p_d    = p_q;
    cs_d   = cs_q;
    addr_d = addr_q;
    if (clr_i) begin
      wr_p_d = 1'b1;
      p_d    = '0;
      cs_d   = '0;
      addr_d = '0;
    end else if (adv_i) begin
      if (wr_p_q) begin
        if (p_q == P_IDX_W'(P_LAST)) begin
          wr_p_d = 1'b0;
          cs_d   = NUM_SBOX'(1);
          addr_d = '0;
        end else begin
          p_d = p_q + P_IDX_W'(1);
        end
      end else if (addr_q == ADDR_W'(ADDR_LAST)) begin
        addr_d = '0;
        cs_d   = cs_q << 1;
      end else begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_p_q <= 1'b0;
      p_q    <= '0;
      cs_q   <= '0;
      addr_q <= '0;
    end else begin
      wr_p_q <= wr_p_d;
      p_q    <= p_d;
      cs_q   <= cs_d;
      addr_q <= addr_d;
    end
  end

  assign last_write_c = !wr_p_q && cs_q[NUM_SBOX-1] && (addr_q == ADDR_W'(ADDR_LAST));
  assign wr_p_o       = wr_p_q;
  assign p_idx_o      = p_q;
  assign wr_cs_o      = cs_q;
  assign wr_addr_o    = addr_q;

endmodule

// File: rtl/bcrypt_seq.sv
// bcrypt_seq: EksBlowfish schedule sequencer between the host and the Feistel core.
// Runs SETUP, 2^cost LOOP_KEY/LOOP_SALT pairs and CT_ITERS ciphertext passes,
// handshaking each block with the core via blk_start/blk_done.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : bcrypt_seq_if.master (start/cost, status, strobes, write addressing)
//   blk_cnt  : accepted blk_done count, present only with BCRYPT_SEQ_PERF_EN defined
module bcrypt_seq
  import bcrypt_pkg::*;
#(
  parameter int unsigned COST_W       = 5,
  parameter int unsigned NUM_SBOX     = 4,
  parameter int unsigned SBOX_WORDS   = 256,
  parameter int unsigned P_PAIRS      = 9,
  parameter int unsigned CTEXT_BLOCKS = 3,
  parameter int unsigned CT_ITERS     = 64
) (
  input  logic              clk,
  input  logic              rst,
  bcrypt_seq_if.master      bus
`ifdef BCRYPT_SEQ_PERF_EN
  ,
  output logic [PERF_W-1:0] blk_cnt
`endif
);

  localparam int unsigned LOOP_W   = 1 << COST_W;
  localparam int unsigned CT_IDX_W = idx_w(CTEXT_BLOCKS);
  localparam int unsigned ITER_W   = idx_w(CT_ITERS);

  phase_t              phase_q, phase_d;
  sub_t                sub_q, sub_d;
  logic [LOOP_W-1:0]   loop_q, loop_d;
  logic [CT_IDX_W-1:0] ct_blk_q, ct_blk_d;
  logic [ITER_W-1:0]   ct_iter_q, ct_iter_d;
  logic                half_q, half_d;
  logic busy_q, busy_d, done_q, done_d, xor_q, xor_d, sel_q, sel_d, mix_q, mix_d;
  logic bstart_q, bstart_d, wr_en_q, wr_en_d, ct_wr_q, ct_wr_d;
  logic clr_c, adv_c, last_write_c, blk_acc_c, start_acc_c;

  assign start_acc_c = (phase_q == PH_IDLE) && bus.start;
  assign blk_acc_c   = (phase_q != PH_IDLE) && (sub_q == SUB_WAIT) && bus.blk_done;

  bcrypt_wr_addr_gen #(
    .P_PAIRS   (P_PAIRS),
    .NUM_SBOX  (NUM_SBOX),
    .SBOX_WORDS(SBOX_WORDS)
  ) u_addr (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (clr_c),
    .adv_i       (adv_c),
    .wr_p_o      (bus.wr_p),
    .p_idx_o     (bus.p_idx),
    .wr_cs_o     (bus.wr_cs),
    .wr_addr_o   (bus.wr_addr),
    .last_write_c(last_write_c)
  );

  // Next-state and next-output logic; outputs are decoded from the next state.
  always_comb begin
    phase_d   = phase_q;
    sub_d     = sub_q;
    loop_d    = loop_q;
    ct_blk_d  = ct_blk_q;
    ct_iter_d = ct_iter_q;
    half_d    = half_q;
    clr_c     = 1'b0;
    adv_c     = 1'b0;

    if (phase_q == PH_IDLE) begin
      if (start_acc_c) begin
        phase_d   = PH_SETUP;
        sub_d     = SUB_XOR;
        loop_d    = (LOOP_W'(1) << bus.cost) - LOOP_W'(1);
        ct_blk_d  = '0;
        ct_iter_d = '0;
      end
    end else begin
      case (sub_q)
        SUB_XOR: begin
          sub_d  = SUB_ISSUE;
          clr_c  = 1'b1;
          half_d = 1'b0;
        end
        SUB_ISSUE: sub_d = SUB_WAIT;
        SUB_WAIT: begin
          if (blk_acc_c) sub_d = SUB_WRITE;
        end
        SUB_WRITE: begin
          sub_d  = SUB_ISSUE;
          half_d = ~half_q;
          if (phase_q == PH_CTEXT) begin
            if (ct_blk_q == CT_IDX_W'(CTEXT_BLOCKS - 1)) begin
              ct_blk_d = '0;
              if (ct_iter_q == ITER_W'(CT_ITERS - 1)) begin
                phase_d = PH_IDLE;
                sub_d   = SUB_XOR;
              end else begin
                ct_iter_d = ct_iter_q + ITER_W'(1);
              end
            end else begin
              ct_blk_d = ct_blk_q + CT_IDX_W'(1);
            end
          end else begin
            adv_c = 1'b1;
            if (last_write_c) begin
              sub_d = SUB_XOR;
              case (phase_q)
                PH_SETUP:    phase_d = PH_LOOP_KEY;
                PH_LOOP_KEY: phase_d = PH_LOOP_SALT;
                default: begin
                  if (loop_q != '0) begin
                    phase_d = PH_LOOP_KEY;
                    loop_d  = loop_q - LOOP_W'(1);
                  end else begin
                    // Ciphertext passes have no XOR step.
                    phase_d = PH_CTEXT;
                    sub_d   = SUB_ISSUE;
                  end
                end
              endcase
            end
          end
        end
        default: sub_d = SUB_XOR;
      endcase
    end

    busy_d   = (phase_d != PH_IDLE);
    xor_d    = busy_d && (sub_d == SUB_XOR);
    bstart_d = busy_d && (sub_d == SUB_ISSUE);
    ct_wr_d  = (phase_d == PH_CTEXT) && (sub_d == SUB_WRITE);
    wr_en_d  = busy_d && (phase_d != PH_CTEXT) && (sub_d == SUB_WRITE);
    // Block counters only move on leaving WRITE, so the current values apply.
    done_d   = ct_wr_d && (ct_blk_d == CT_IDX_W'(CTEXT_BLOCKS - 1))
                       && (ct_iter_d == ITER_W'(CT_ITERS - 1));
    sel_d    = (phase_d == PH_LOOP_SALT);
    mix_d    = (phase_d == PH_SETUP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q   <= PH_IDLE;
      sub_q     <= SUB_XOR;
      loop_q    <= '0;
      ct_blk_q  <= '0;
      ct_iter_q <= '0;
      half_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      xor_q     <= 1'b0;
      sel_q     <= 1'b0;
      mix_q     <= 1'b0;
      bstart_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      ct_wr_q   <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      sub_q     <= sub_d;
      loop_q    <= loop_d;
      ct_blk_q  <= ct_blk_d;
      ct_iter_q <= ct_iter_d;
      half_q    <= half_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      xor_q     <= xor_d;
      sel_q     <= sel_d;
      mix_q     <= mix_d;
      bstart_q  <= bstart_d;
      wr_en_q   <= wr_en_d;
      ct_wr_q   <= ct_wr_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.phase        = PHASE_W'(phase_q);
  assign bus.xor_p        = xor_q;
  assign bus.salt_key_sel = sel_q;
  assign bus.mix_salt     = mix_q;
  assign bus.salt_half    = half_q;
  assign bus.blk_start    = bstart_q;
  assign bus.wr_en        = wr_en_q;
  assign bus.ct_wr        = ct_wr_q;
  assign bus.ct_idx       = ct_blk_q;

`ifdef BCRYPT_SEQ_PERF_EN
  logic [PERF_W-1:0] blk_cnt_q;

  // Saturating count of accepted Feistel results for the current hash.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_cnt_q <= '0;
    end else if (start_acc_c) begin
      blk_cnt_q <= '0;
    end else if (blk_acc_c && (blk_cnt_q != '1)) begin
      blk_cnt_q <= blk_cnt_q + PERF_W'(1);
    end
  end

  assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_bcrypt_seq.sv
// tb_bcrypt_seq: self-checking bench for bcrypt_seq in a reduced configuration
// (2 P pairs, 2 S-boxes of 4 words, 1 ciphertext block, 2 passes).
// Optional blk_cnt checks follow BCRYPT_SEQ_PERF_EN.
module tb_bcrypt_seq;
  import bcrypt_pkg::*;

  localparam int unsigned CW  = 5;
  localparam int unsigned NSB = 2;
  localparam int unsigned SW  = 4;
  localparam int unsigned PP  = 2;
  localparam int unsigned CB  = 1;
  localparam int unsigned CI  = 2;
  localparam int WPE = PP + NSB * SW / 2;   // writes per expansion

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcrypt_seq_if #(.COST_W(CW), .NUM_SBOX(NSB), .SBOX_WORDS(SW), .CTEXT_BLOCKS(CB)) bus ();
`ifdef BCRYPT_SEQ_PERF_EN
  logic [31:0] blk_cnt;
`endif

  bcrypt_seq #(
    .COST_W(CW), .NUM_SBOX(NSB), .SBOX_WORDS(SW), .P_PAIRS(PP),
    .CTEXT_BLOCKS(CB), .CT_ITERS(CI)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef BCRYPT_SEQ_PERF_EN
    ,
    .blk_cnt(blk_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected write record, produced from the schedule rules alone.
  typedef struct {
    int ph; bit wp; int pidx; int cs; int addr; bit ct; int ctidx; int half;
  } wr_t;
  wr_t exp_q[$];
  int  sel_exp[$];

  function automatic void build_model(input int c);
    int nexp;
    int k;
    exp_q.delete();
    sel_exp.delete();
    nexp = 1 + 2 * (1 << c);
    for (int e = 0; e < nexp; e++) begin
      int ph;
      ph = (e == 0) ? 1 : ((e % 2 == 1) ? 2 : 3);
      sel_exp.push_back((ph == 3) ? 1 : 0);
      k = 0;
      for (int i = 0; i < PP; i++) begin
        exp_q.push_back('{ph, 1'b1, i, 0, 0, 1'b0, 0, k % 2});
        k++;
      end
      for (int s = 0; s < NSB; s++)
        for (int a = 0; a < SW / 2; a++) begin
          exp_q.push_back('{ph, 1'b0, 0, 1 << s, a, 1'b0, 0, k % 2});
          k++;
        end
    end
    for (int it = 0; it < CI; it++)
      for (int b = 0; b < CB; b++)
        exp_q.push_back('{4, 1'b0, 0, 0, 0, 1'b1, b, 0});
  endfunction

  function automatic int model_done(input int c, input int lat);
    return (1 + 2 * (1 << c)) * (1 + WPE * (lat + 2)) + CI * CB * (lat + 2);
  endfunction

  function automatic int model_starts(input int c);
    return (1 + 2 * (1 << c)) * WPE + CI * CB;
  endfunction

  task automatic check_all_zero(input string name);
    logic [63:0] v;
    v = 64'({bus.busy, bus.done, bus.phase, bus.xor_p, bus.salt_key_sel, bus.mix_salt,
             bus.salt_half, bus.blk_start, bus.wr_en, bus.wr_p, bus.p_idx, bus.wr_cs,
             bus.wr_addr, bus.ct_wr, bus.ct_idx});
    check(name, v, 64'd0);
  endtask

  // Runs one hash from a sample point (#1 after posedge); cycle 1 is the first post-start cycle.
  task automatic run_hash(input int c, input int lat, input bit spur, input bit mid_start,
                          input bit abort_salt, output int done_cyc, output int n_start);
    int  cyc;
    int  fire;
    int  busy_gap;
    bit  fin;
    bit  mid_done;
    wr_t e;
    build_model(c);
    cyc = 0; fire = -1; busy_gap = 0; fin = 0; mid_done = 0;
    done_cyc = -1; n_start = 0;
    bus.cost  = CW'(c);
    bus.start = 1'b1;
    while (!fin && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
      bus.start    = 1'b0;
      bus.blk_done = (cyc == fire) || (spur && (bus.blk_start || bus.wr_en || bus.ct_wr));
      if (bus.blk_start) begin
        n_start++;
        fire = cyc + lat;
      end
      if (cyc == 1) begin
        check("first_cycle_xor", {bus.xor_p, bus.busy, bus.phase}, {2'b11, 3'd1});
`ifdef BCRYPT_SEQ_PERF_EN
        check("blk_cnt_cleared", blk_cnt, 0);
`endif
      end
      if (bus.busy !== 1'b1) busy_gap++;
      if (bus.xor_p) begin
        if (sel_exp.size() == 0) check("xor_extra", 1, 0);
        else check("salt_key_sel", bus.salt_key_sel, sel_exp.pop_front());
      end
      if (bus.wr_en || bus.ct_wr) begin
        if (exp_q.size() == 0) begin
          check("extra_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("wr_phase", bus.phase, e.ph);
          check("wr_kind", {bus.wr_en, bus.ct_wr, bus.wr_p}, {~e.ct, e.ct, e.wp});
          check("mix_salt", bus.mix_salt, (e.ph == 1) ? 1 : 0);
          if (e.wp) check("p_idx_cs", {bus.p_idx, bus.wr_cs}, {4'(e.pidx), NSB'(0)});
          else if (!e.ct) check("cs_addr", {bus.wr_cs, bus.wr_addr}, {NSB'(e.cs), 1'(e.addr)});
          if (e.ct) check("ct_idx", bus.ct_idx, e.ctidx);
          if (e.ph == 1) check("salt_half", bus.salt_half, e.half);
        end
      end
      if (mid_start && !mid_done && bus.phase == 3'd2) begin
        bus.start = 1'b1;
        bus.cost  = CW'(3);
        mid_done  = 1;
      end
      if (abort_salt && bus.phase == 3'd3) begin
        rst = 1'b1;
        bus.blk_done = 1'b0;
        @(posedge clk); #1;
        check_all_zero("abort_outputs_zero");
        rst = 1'b0;
        return;
      end
      if (bus.done) begin
        done_cyc = cyc;
        fin = 1;
      end
    end
    bus.blk_done = 1'b0;
    if (!fin) check("done_timeout", 0, 1);
    check("busy_gap", busy_gap, 0);
    check("writes_left", exp_q.size(), 0);
    check("xor_left", sel_exp.size(), 0);
    @(posedge clk); #1;
    check("after_done_idle", {bus.busy, bus.done, bus.phase}, 5'd0);
  endtask

  typedef struct { int c; int lat; bit spur; int starts; int done_c; } vec_t;
  vec_t tbl[4];

  initial begin
    int dc, ns, c, lat;
    tbl[0] = '{0, 1, 1'b0, 20, 63};
    tbl[1] = '{2, 1, 1'b0, 56, 177};
    tbl[2] = '{0, 6, 1'b1, 20, 163};
    tbl[3] = '{1, 2, 1'b0, 32, 133};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.cost = '0;
    bus.blk_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_outputs_zero");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      run_hash(tbl[i].c, tbl[i].lat, tbl[i].spur, 1'b0, 1'b0, dc, ns);
      check($sformatf("vec%0d_starts", i), ns, tbl[i].starts);
      check($sformatf("vec%0d_done_cycle", i), dc, tbl[i].done_c);
`ifdef BCRYPT_SEQ_PERF_EN
      check($sformatf("vec%0d_blk_cnt", i), blk_cnt, tbl[i].starts);
`endif
      repeat (2) @(posedge clk);
      #1;
    end

    // Start during LOOP_KEY must not disturb the running hash.
    run_hash(0, 1, 1'b0, 1'b1, 1'b0, dc, ns);
    check("midstart_starts", ns, 20);
    check("midstart_done_cycle", dc, 63);

    // Reset during LOOP_SALT, then a fresh cost-0 hash.
    run_hash(1, 1, 1'b0, 1'b0, 1'b1, dc, ns);
    run_hash(0, 1, 1'b0, 1'b0, 1'b0, dc, ns);
    check("post_rst_starts", ns, 20);
    check("post_rst_done_cycle", dc, 63);

    for (int r = 0; r < 3; r++) begin
      c   = int'($urandom_range(0, 3));
      lat = int'($urandom_range(1, 4));
      run_hash(c, lat, 1'b0, 1'b0, 1'b0, dc, ns);
      check($sformatf("rand%0d_starts", r), ns, model_starts(c));
      check($sformatf("rand%0d_done_cycle", r), dc, model_done(c, lat));
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
